// File: rtl/memory_access.sv
`default_nettype none
// ==========================================================================
// memory_access : pipeline M stage, one dbus transaction per memory op
// Rev 1.0 -- optional build macro: MEM_MISALIGN_CHECK_EN
// ==========================================================================
package memory_access_pkg;
   localparam int XLEN   = 64;
   localparam int ADDR_W = 64;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [1:0] msize;
      logic       msigned;
   } ctl_t;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [31:0]       raw_instr;
      logic [4:0]        dst;
      logic [XLEN-1:0]   aluout;
      logic [XLEN-1:0]   storedata;
      ctl_t              ctl;
   } execute_data_t;

   typedef struct packed {
      logic              valid;
      logic [XLEN-1:0]   pc;
      logic [31:0]       raw_instr;
      logic [4:0]        dst;
      logic [XLEN-1:0]   writedata;
      ctl_t              ctl;
   } memory_data_t;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [1:0]        size;
      logic [7:0]        strobe;
      logic [XLEN-1:0]   data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [XLEN-1:0]   data;
   } dbus_resp_t;
endpackage

module memory_access
   import memory_access_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   input  execute_data_t dataE,
   output logic          in_ready,
   output memory_data_t  dataM,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp,
   output logic          misalign
);
   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DRAIN = 2'd3} state_e;

   state_e          state_q, state_d;
   execute_data_t   hold_q, hold_d;
   logic            kill_q, kill_d;
   memory_data_t    dataM_q, dataM_d;
   logic            accept, is_mem, bad_align, complete;
   logic [2:0]      off;
   logic [7:0]      byte_mask;
   logic [XLEN-1:0] shifted, load_val;

   assign off      = hold_q.aluout[2:0];
   assign is_mem   = dataE.ctl.memread | dataE.ctl.memwrite;
   assign in_ready = (state_q == IDLE) & ~flush;
   assign accept   = dataE.valid & in_ready;
   assign dataM    = dataM_q;

`ifdef MEM_MISALIGN_CHECK_EN
   logic [2:0] align_mask;
   logic       misalign_q;

   assign align_mask = 3'((4'd1 << dataE.ctl.msize) - 4'd1);
   assign bad_align  = is_mem & (|(dataE.aluout[2:0] & align_mask));
   assign misalign   = misalign_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) misalign_q <= 1'b0;
      else          misalign_q <= accept & bad_align;
   end
`else
   assign bad_align = 1'b0;
   assign misalign  = 1'b0;
`endif

   always_comb begin
      case (hold_q.ctl.msize)
         2'd0:    byte_mask = 8'h01;
         2'd1:    byte_mask = 8'h03;
         2'd2:    byte_mask = 8'h0F;
         default: byte_mask = 8'hFF;
      endcase
   end

   // Request fields come straight from the held instruction, so they stay stable until addr_ok.
   always_comb begin
      dreq = '0;
      if (state_q == REQ) begin
         dreq.valid = 1'b1;
         dreq.addr  = hold_q.aluout;
         dreq.size  = hold_q.ctl.msize;
         if (hold_q.ctl.memwrite) begin
            dreq.strobe = byte_mask << off;
            dreq.data   = hold_q.storedata << {off, 3'b000};
         end
      end
   end

   always_comb begin
      shifted = dresp.data >> {off, 3'b000};
      case (hold_q.ctl.msize)
         2'd0:    load_val = {{(XLEN-8){hold_q.ctl.msigned & shifted[7]}}, shifted[7:0]};
         2'd1:    load_val = {{(XLEN-16){hold_q.ctl.msigned & shifted[15]}}, shifted[15:0]};
         2'd2:    load_val = {{(XLEN-32){hold_q.ctl.msigned & shifted[31]}}, shifted[31:0]};
         default: load_val = shifted;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      kill_d   = kill_q;
      dataM_d  = '0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_mem && !bad_align) begin
                  hold_d  = dataE;
                  kill_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  dataM_d.valid     = 1'b1;
                  dataM_d.pc        = dataE.pc;
                  dataM_d.raw_instr = dataE.raw_instr;
                  dataM_d.dst       = dataE.dst;
                  dataM_d.writedata = dataE.aluout;
                  dataM_d.ctl       = dataE.ctl;
                  if (bad_align) dataM_d.ctl.regwrite = 1'b0;
               end
            end
         end
         REQ: begin
            // A flushed request is still carried through the handshake, then its data drained.
            kill_d = kill_q | flush;
            if (dresp.addr_ok) begin
               if (dresp.data_ok) begin
                  state_d  = IDLE;
                  complete = ~(kill_q | flush);
               end else begin
                  state_d  = (kill_q | flush) ? DRAIN : WAIT;
               end
            end
         end
         WAIT: begin
            if (dresp.data_ok) begin
               state_d  = IDLE;
               complete = ~flush;
            end else if (flush) begin
               state_d  = DRAIN;
            end
         end
         DRAIN: begin
            if (dresp.data_ok) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (complete) begin
         dataM_d.valid     = hold_q.valid;
         dataM_d.pc        = hold_q.pc;
         dataM_d.raw_instr = hold_q.raw_instr;
         dataM_d.dst       = hold_q.dst;
         dataM_d.writedata = hold_q.ctl.memread ? load_val : hold_q.aluout;
         dataM_d.ctl       = hold_q.ctl;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         kill_q  <= 1'b0;
         dataM_q <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         kill_q  <= kill_d;
         dataM_q <= dataM_d;
      end
   end
endmodule
`default_nettype wire
